// File: rtl/strip_allocator.sv
// First-fit strip allocator for the 128x128 array: places a (w,h) block into one of
// 13 strips by height class and reports the strip ID and the block's x position.
module strip_allocator (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [4:0] in_width_i,
  input  logic [4:0] in_height_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] out_strip_id_o,
  output logic [7:0] out_x_o,
  output logic       out_reject_o
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t     state;
  logic [4:0] w_q;
  logic [4:0] h_q;
  logic [2:0] j_q;
  logic       vld_p0;
  logic [3:0] cand_p0;
  logic [7:0] fill_p0;
  logic [7:0] fill [0:15];

  logic [1:0] cls;
  logic [3:0] cand_cur;
  logic [3:0] cand_nxt;
  logic [8:0] sum;
  logic       fits;
  logic       bad;
  logic       last;

  function automatic logic [1:0] cls_of(input logic [4:0] h);
    if (h <= 5'd7)       return 2'd0;
    else if (h == 5'd8)  return 2'd1;
    else                 return 2'd2;
  endfunction

  // Class A walks even strips from 2, class B odd strips from 1, class C strips 12..13.
  function automatic logic [3:0] cand_of(input logic [1:0] c, input logic [2:0] j);
    logic [3:0] jj;
    jj = {1'b0, j};
    case (c)
      2'd0:    return (jj << 1) + 4'd2;
      2'd1:    return (jj << 1) + 4'd1;
      default: return jj + 4'd12;
    endcase
  endfunction

  function automatic logic [2:0] last_of(input logic [1:0] c);
    case (c)
      2'd0:    return 3'd4;
      2'd1:    return 3'd5;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic illegal(input logic [4:0] w, input logic [4:0] h);
    return (h == 5'd0) || (h > 5'd16) || (w == 5'd0) || (w > 5'd16);
  endfunction

  always_comb begin
    cls      = cls_of(h_q);
    cand_cur = cand_of(cls, j_q);
    cand_nxt = cand_of(cls, j_q + 3'd1);
    sum      = {1'b0, fill_p0} + {4'b0, w_q};
    fits     = (sum <= 9'd128);
    bad      = illegal(w_q, h_q);
    last     = (j_q == last_of(cls));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      in_ready_o     <= 1'b1;
      out_valid_o    <= 1'b0;
      out_strip_id_o <= '0;
      out_x_o        <= '0;
      out_reject_o   <= 1'b0;
      w_q            <= '0;
      h_q            <= '0;
      j_q            <= '0;
      vld_p0         <= 1'b0;
      cand_p0        <= '0;
      fill_p0        <= '0;
      for (int s = 0; s < 16; s++) fill[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            w_q        <= in_width_i;
            h_q        <= in_height_i;
            j_q        <= '0;
            vld_p0     <= 1'b0;
            in_ready_o <= 1'b0;
            state      <= SEARCH;
          end
        end
        SEARCH: begin
          // p0: fetch the fill level of candidate j; p1: judge it and fetch j+1 in parallel.
          if (!vld_p0) begin
            cand_p0 <= cand_cur;
            fill_p0 <= fill[cand_cur];
            vld_p0  <= 1'b1;
          end else if (bad || (!fits && last)) begin
            out_strip_id_o <= '0;
            out_x_o        <= '0;
            out_reject_o   <= 1'b1;
            out_valid_o    <= 1'b1;
            state          <= DONE;
          end else if (fits) begin
            out_strip_id_o <= cand_p0;
            out_x_o        <= fill_p0;
            out_reject_o   <= 1'b0;
            out_valid_o    <= 1'b1;
            fill[cand_p0]  <= sum[7:0];
            state          <= DONE;
          end else begin
            j_q     <= j_q + 3'd1;
            cand_p0 <= cand_nxt;
            fill_p0 <= fill[cand_nxt];
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
